// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result producers/issue logic and the
// register-file write-port arbiter.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic [3:0]  nD;
  logic [15:0] D;
  logic        RegWE;
  logic [15:0] busy;
  logic        idle;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd,
    input  alu_ready, mem_ready, nD, D, RegWE, busy, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd,
    output alu_ready, mem_ready, nD, D, RegWE, busy, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback front-end: per-source FIFOs for ALU and load results,
// round-robin onto the single write port, plus a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          Reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // Entry layout {rd, data}; index 0 is the ALU source, index 1 the MEM source.
  typedef logic [19:0] entry_t;

  entry_t          fifo_q [2][DEPTH];
  entry_t          in_entry [2];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q [2];
  logic [AW-1:0]   wr_ptr_d [2];
  logic [AW-1:0]   rd_ptr_q [2];
  logic [AW-1:0]   rd_ptr_d [2];
  logic [AW:0]     cnt_q [2];
  logic [AW:0]     cnt_d [2];
  logic [1:0]      in_vld, push, pop, nonempty;
  logic            last_mem_q, last_mem_d;
  logic            we_q, we_d;
  logic [3:0]      nd_q, nd_d;
  logic [15:0]     d_q, d_d;
  logic [15:0]     busy_q, busy_d, set_mask, clr_mask;

  always_comb begin
    in_vld      = {bus.mem_valid, bus.alu_valid};
    in_entry[0] = {bus.alu_rd, bus.alu_data};
    in_entry[1] = {bus.mem_rd, bus.mem_data};
    for (int s = 0; s < 2; s++) begin
      nonempty[s] = (cnt_q[s] != '0);
      push[s]     = in_vld[s] && (cnt_q[s] != CNT_FULL);
    end

    // Round-robin: on contention the source not granted last wins.
    pop[0] = nonempty[0] && (!nonempty[1] || last_mem_q);
    pop[1] = nonempty[1] && !pop[0];

    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + AW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + AW'(pop[s]);
      cnt_d[s]    = cnt_q[s];
      case ({push[s], pop[s]})
        2'b10:   cnt_d[s] = cnt_q[s] + 1'b1;
        2'b01:   cnt_d[s] = cnt_q[s] - 1'b1;
        default: cnt_d[s] = cnt_q[s];
      endcase
    end

    head       = pop[1] ? fifo_q[1][rd_ptr_q[1]] : fifo_q[0][rd_ptr_q[0]];
    last_mem_d = last_mem_q;
    if (pop[0])      last_mem_d = 1'b0;
    else if (pop[1]) last_mem_d = 1'b1;

    we_d = 1'b0;
    nd_d = nd_q;
    d_d  = d_q;
    if ((|pop) && !(DROP_R0 && (head[19:16] == 4'd0))) begin
      we_d = 1'b1;
      nd_d = head[19:16];
      d_d  = head[15:0];
    end

    clr_mask = we_q ? (16'd1 << nd_q) : 16'd0;
    set_mask = (bus.issue_valid && !(DROP_R0 && (bus.issue_rd == 4'd0)))
               ? (16'd1 << bus.issue_rd) : 16'd0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) fifo_q[s][wr_ptr_q[s]] <= in_entry[s];
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      last_mem_q <= 1'b1;
      we_q       <= 1'b0;
      nd_q       <= 4'd0;
      d_q        <= 16'd0;
      busy_q     <= 16'd0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      last_mem_q <= last_mem_d;
      we_q       <= we_d;
      nd_q       <= nd_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.alu_ready = (cnt_q[0] != CNT_FULL);
  assign bus.mem_ready = (cnt_q[1] != CNT_FULL);
  assign bus.nD        = nd_q;
  assign bus.D         = d_q;
  assign bus.RegWE     = we_q;
  assign bus.busy      = busy_q;
  assign bus.idle      = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !we_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, arbitration order,
// backpressure, r0 dropping and scoreboard set/clear priority.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  typedef struct {
    int          c;
    logic [3:0]  rd;
    logic [15:0] d;
  } wr_t;
  wr_t log_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.DEPTH(4), .DROP_R0(1'b1)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.RegWE === 1'b1) log_q.push_back('{cyc, bus.nD, bus.D});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.alu_valid = 1'b0; bus.alu_rd = 4'd0; bus.alu_data = 16'd0;
    bus.mem_valid = 1'b0; bus.mem_rd = 4'd0; bus.mem_data = 16'd0;
    bus.issue_valid = 1'b0; bus.issue_rd = 4'd0;
  endtask

  task automatic do_reset();
    quiet();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    quiet();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    total++;
    if ({bus.RegWE, bus.nD, bus.D, bus.busy, bus.alu_ready, bus.mem_ready, bus.idle}
        !== {1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got we=%b nD=%0d D=%h busy=%h ar=%b mr=%b idle=%b exp 0/0/0000/0000/1/1/1",
               bus.RegWE, bus.nD, bus.D, bus.busy, bus.alu_ready, bus.mem_ready, bus.idle);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 4'd4;
    for (int i = 0; i < 2; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 4'd1 + 4'(i); bus.alu_data = 16'h1100 + 16'(i);
      bus.mem_valid = 1'b1; bus.mem_rd = 4'd8 + 4'(i); bus.mem_data = 16'h2200 + 16'(i);
      step();
      bus.issue_valid = 1'b0;
    end
    total++;
    if ({bus.RegWE, bus.busy} !== {1'b1, 16'h0010}) begin
      bad++;
      $display("FAIL mid_prereset got we=%b busy=%h exp we=1 busy=0010", bus.RegWE, bus.busy);
    end
    quiet();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    total++;
    if ({bus.RegWE, bus.nD, bus.D, bus.busy, bus.alu_ready, bus.mem_ready, bus.idle}
        !== {1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_state got we=%b nD=%0d D=%h busy=%h ar=%b mr=%b idle=%b exp 0/0/0000/0000/1/1/1",
               bus.RegWE, bus.nD, bus.D, bus.busy, bus.alu_ready, bus.mem_ready, bus.idle);
    end
    log_q.delete();
    repeat (6) step();
    total++;
    if (log_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_nowrite got writes=%0d exp 0", log_q.size());
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 16'h1234;
    step();
    bus.alu_valid = 1'b0;
    total++;
    if ({bus.RegWE, bus.idle} !== 2'b00) begin
      bad++;
      $display("FAIL single_k got we=%b idle=%b exp we=0 idle=0", bus.RegWE, bus.idle);
    end
    step();
    total++;
    if ({bus.RegWE, bus.nD, bus.D} !== {1'b1, 4'd3, 16'h1234}) begin
      bad++;
      $display("FAIL single_write got we=%b nD=%0d D=%h exp we=1 nD=3 D=1234", bus.RegWE, bus.nD, bus.D);
    end
    step();
    total++;
    if ({bus.RegWE, bus.idle} !== 2'b01) begin
      bad++;
      $display("FAIL single_after got we=%b idle=%b exp we=0 idle=1", bus.RegWE, bus.idle);
    end
  endtask

  task automatic test_contention();
    logic [3:0]  exp_rd [6];
    logic [15:0] exp_d  [6];
    int n;
    exp_rd = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
    exp_d  = '{16'hA001, 16'hB009, 16'hA002, 16'hB00A, 16'hA003, 16'hB00B};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 4'd1 + 4'(i); bus.alu_data = 16'hA001 + 16'(i);
      bus.mem_valid = 1'b1; bus.mem_rd = 4'd9 + 4'(i); bus.mem_data = 16'hB009 + 16'(i);
      step();
    end
    quiet();
    repeat (8) step();
    total++;
    if (log_q.size() != 6) begin
      bad++;
      $display("FAIL contention_count got=%0d exp=6", log_q.size());
    end
    n = (log_q.size() < 6) ? log_q.size() : 6;
    for (int i = 0; i < n; i++) begin
      total++;
      if ({log_q[i].rd, log_q[i].d} !== {exp_rd[i], exp_d[i]}) begin
        bad++;
        $display("FAIL contention_order[%0d] got r%0d=%h exp r%0d=%h", i,
                 log_q[i].rd, log_q[i].d, exp_rd[i], exp_d[i]);
      end
      if (i > 0) begin
        total++;
        if (log_q[i].c - log_q[i-1].c != 1) begin
          bad++;
          $display("FAIL contention_gap[%0d] got delta=%0d exp 1", i, log_q[i].c - log_q[i-1].c);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int aseq, mseq, ai, mi;
    logic acc_a, acc_m;
    do_reset();
    aseq = 0; mseq = 0;
    for (int e = 1; e <= 12; e++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 4'd1 + 4'(aseq % 7); bus.alu_data = 16'hA000 + 16'(aseq);
      bus.mem_valid = 1'b1; bus.mem_rd = 4'd8 + 4'(mseq % 7); bus.mem_data = 16'hC000 + 16'(mseq);
      acc_a = bus.alu_ready;
      acc_m = bus.mem_ready;
      step();
      if (acc_a) aseq++;
      if (acc_m) mseq++;
      if (e == 6) begin
        total++;
        if ({bus.alu_ready, bus.mem_ready} !== 2'b10) begin
          bad++;
          $display("FAIL bp_ready_e6 got ar=%b mr=%b exp ar=1 mr=0", bus.alu_ready, bus.mem_ready);
        end
      end
      if (e == 7) begin
        total++;
        if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
          bad++;
          $display("FAIL bp_ready_e7 got ar=%b mr=%b exp ar=0 mr=1", bus.alu_ready, bus.mem_ready);
        end
      end
    end
    quiet();
    total++;
    if (aseq != 9 || mseq != 9) begin
      bad++;
      $display("FAIL bp_accepted got alu=%0d mem=%0d exp 9/9", aseq, mseq);
    end
    repeat (12) step();
    total++;
    if (log_q.size() != 18) begin
      bad++;
      $display("FAIL bp_writes got=%0d exp=18", log_q.size());
    end
    ai = 0; mi = 0;
    foreach (log_q[i]) begin
      total++;
      if (log_q[i].d[15:12] == 4'hA) begin
        if ({log_q[i].rd, log_q[i].d} !== {4'd1 + 4'(ai % 7), 16'hA000 + 16'(ai)}) begin
          bad++;
          $display("FAIL bp_alu_order[%0d] got r%0d=%h exp r%0d=%h", ai, log_q[i].rd, log_q[i].d,
                   4'd1 + 4'(ai % 7), 16'hA000 + 16'(ai));
        end
        ai++;
      end else if (log_q[i].d[15:12] == 4'hC) begin
        if ({log_q[i].rd, log_q[i].d} !== {4'd8 + 4'(mi % 7), 16'hC000 + 16'(mi)}) begin
          bad++;
          $display("FAIL bp_mem_order[%0d] got r%0d=%h exp r%0d=%h", mi, log_q[i].rd, log_q[i].d,
                   4'd8 + 4'(mi % 7), 16'hC000 + 16'(mi));
        end
        mi++;
      end else begin
        bad++;
        $display("FAIL bp_unknown_entry got r%0d=%h exp an Axxx or Cxxx entry", log_q[i].rd, log_q[i].d);
      end
    end
    total++;
    if (ai != 9 || mi != 9) begin
      bad++;
      $display("FAIL bp_per_source got alu=%0d mem=%0d exp 9/9", ai, mi);
    end
  endtask

  task automatic test_r0_drop();
    do_reset();
    bus.mem_valid = 1'b1; bus.mem_rd = 4'd0; bus.mem_data = 16'hBEEF;
    bus.issue_valid = 1'b1; bus.issue_rd = 4'd0;
    step();
    quiet();
    total++;
    if (bus.busy !== 16'h0000) begin
      bad++;
      $display("FAIL r0_issue_busy got=%h exp=0000", bus.busy);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd5; bus.alu_data = 16'h0001;
    step();
    quiet();
    repeat (5) step();
    total++;
    if (log_q.size() != 1) begin
      bad++;
      $display("FAIL r0_write_count got=%0d exp=1", log_q.size());
    end else begin
      total++;
      if ({log_q[0].rd, log_q[0].d} !== {4'd5, 16'h0001}) begin
        bad++;
        $display("FAIL r0_survivor got r%0d=%h exp r5=0001", log_q[0].rd, log_q[0].d);
      end
    end
    total++;
    if (bus.busy !== 16'h0000) begin
      bad++;
      $display("FAIL r0_busy_end got=%h exp=0000", bus.busy);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    bus.issue_valid = 1'b1; bus.issue_rd = 4'd7;
    step();
    bus.issue_valid = 1'b0;
    total++;
    if (bus.busy !== 16'h0080) begin
      bad++;
      $display("FAIL sb_set got=%h exp=0080", bus.busy);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h7777;
    step();
    bus.alu_valid = 1'b0;
    step();
    total++;
    if ({bus.RegWE, bus.nD} !== {1'b1, 4'd7}) begin
      bad++;
      $display("FAIL sb_write7 got we=%b nD=%0d exp we=1 nD=7", bus.RegWE, bus.nD);
    end
    bus.issue_valid = 1'b1; bus.issue_rd = 4'd7;
    step();
    bus.issue_valid = 1'b0;
    step();
    total++;
    if (bus.busy !== 16'h0080) begin
      bad++;
      $display("FAIL sb_set_wins got=%h exp=0080", bus.busy);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h7778;
    step();
    bus.alu_valid = 1'b0;
    step();
    bus.issue_valid = 1'b1; bus.issue_rd = 4'd2;
    step();
    bus.issue_valid = 1'b0;
    total++;
    if (bus.busy !== 16'h0004) begin
      bad++;
      $display("FAIL sb_set_clear_diff got=%h exp=0004", bus.busy);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd2; bus.alu_data = 16'h2222;
    step();
    bus.alu_valid = 1'b0;
    step(); step();
    total++;
    if (bus.busy !== 16'h0000) begin
      bad++;
      $display("FAIL sb_clear got=%h exp=0000", bus.busy);
    end
  endtask

  initial begin
    quiet();
    test_reset();
    test_reset_mid();
    test_single();
    test_contention();
    test_backpressure();
    test_r0_drop();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
